// File: rtl/led_pwm_engine.sv
// LED output stage: per-LED 8-bit PWM, shared group dimming/blinking, shadowed register updates.
// Optional LED_ACTIVE_LOW_EN inverts the leds pins for open-drain active-low drive.
module led_pwm_engine #(
  parameter int NUM_LEDS       = 4,
  parameter int BLINK_PRESCALE = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sleep,
  input  logic [NUM_LEDS*8-1:0] duty,
  input  logic [7:0]            grppwm,
  input  logic [7:0]            grpfreq,
  input  logic                  dmblnk,
  input  logic [NUM_LEDS*2-1:0] ledout,
  output logic [NUM_LEDS-1:0]   leds,
  output logic                  period_wrap
);

  localparam int PW = $clog2(BLINK_PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(BLINK_PRESCALE - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic POLARITY = 1'b1;
`else
  localparam logic POLARITY = 1'b0;
`endif

  localparam logic [NUM_LEDS-1:0] LEDS_IDLE = {NUM_LEDS{POLARITY}};

  logic [7:0]            r_pwmCnt;
  logic [7:0]            r_grpCnt;
  logic [PW-1:0]         r_presc;
  logic [7:0]            r_div;
  logic [NUM_LEDS*8-1:0] r_dutySh;
  logic [7:0]            r_grppwmSh;
  logic [7:0]            r_grpfreqSh;
  logic                  r_dmblnkSh;
  logic [NUM_LEDS*2-1:0] r_ledoutSh;
  logic [NUM_LEDS-1:0]   r_leds;

  logic                  w_wrap;
  logic                  w_modeChange;
  logic                  w_grpOn;
  logic [NUM_LEDS-1:0]   w_lit;

  assign w_wrap       = (r_pwmCnt == 8'hFF) && !sleep;
  assign w_modeChange = w_wrap && (dmblnk != r_dmblnkSh);
  assign w_grpOn      = (r_grpCnt < r_grppwmSh);
  assign period_wrap  = w_wrap;
  assign leds         = r_leds;

  // Shadows only move on the wrap edge so a period never sees a half-applied update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwmCnt    <= 8'h00;
      r_dutySh    <= '0;
      r_grppwmSh  <= 8'h00;
      r_grpfreqSh <= 8'h00;
      r_dmblnkSh  <= 1'b0;
      r_ledoutSh  <= '0;
    end else if (sleep) begin
      r_pwmCnt <= 8'h00;
    end else begin
      r_pwmCnt <= r_pwmCnt + 8'h01;
      if (w_wrap) begin
        r_dutySh    <= duty;
        r_grppwmSh  <= grppwm;
        r_grpfreqSh <= grpfreq;
        r_dmblnkSh  <= dmblnk;
        r_ledoutSh  <= ledout;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc  <= '0;
      r_div    <= 8'h00;
      r_grpCnt <= 8'h00;
    end else if (sleep || w_modeChange) begin
      r_presc  <= '0;
      r_div    <= 8'h00;
      r_grpCnt <= 8'h00;
    end else if (!r_dmblnkSh) begin
      r_presc <= '0;
      r_div   <= 8'h00;
      if (w_wrap) begin
        r_grpCnt <= r_grpCnt + 8'h01;
      end
    end else if (r_presc == PRESC_LAST) begin
      // Blink tick: the divider stretches each group phase to grpfreq+1 ticks.
      r_presc <= '0;
      if (r_div == r_grpfreqSh) begin
        r_div    <= 8'h00;
        r_grpCnt <= r_grpCnt + 8'h01;
      end else begin
        r_div <= r_div + 8'h01;
      end
    end else begin
      r_presc <= r_presc + PRESC_ONE;
    end
  end

  always_comb begin
    w_lit = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (r_ledoutSh[2*i +: 2])
        2'b00:   w_lit[i] = 1'b0;
        2'b01:   w_lit[i] = 1'b1;
        2'b10:   w_lit[i] = (r_pwmCnt < r_dutySh[8*i +: 8]);
        default: w_lit[i] = (r_pwmCnt < r_dutySh[8*i +: 8]) && w_grpOn;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_leds <= LEDS_IDLE;
    end else if (sleep) begin
      r_leds <= LEDS_IDLE;
    end else begin
      r_leds <= w_lit ^ LEDS_IDLE;
    end
  end

endmodule

// File: tb/tb_led_pwm_engine.sv
// Directed scoreboard bench for led_pwm_engine (default active-high build, BLINK_PRESCALE = 4).
module tb_led_pwm_engine;

  localparam int NUM_LEDS = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  sleep;
  logic [NUM_LEDS*8-1:0] duty;
  logic [7:0]            grppwm;
  logic [7:0]            grpfreq;
  logic                  dmblnk;
  logic [NUM_LEDS*2-1:0] ledout;
  logic [NUM_LEDS-1:0]   leds;
  logic                  periodWrap;

  int checkCount = 0;
  int errorCount = 0;
  int wrapCount  = 0;

  typedef struct {
    string tag;
    int    value;
  } expect_t;

  expect_t scoreboard[$];

  led_pwm_engine #(
    .NUM_LEDS      (NUM_LEDS),
    .BLINK_PRESCALE(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sleep      (sleep),
    .duty       (duty),
    .grppwm     (grppwm),
    .grpfreq    (grpfreq),
    .dmblnk     (dmblnk),
    .ledout     (ledout),
    .leds       (leds),
    .period_wrap(periodWrap)
  );

  always #5 clk = ~clk;

  // Every cycle of the main sequence goes through here so the wrap count stays exact.
  task automatic step();
    @(negedge clk);
    if (periodWrap) wrapCount++;
  endtask

  task automatic pushExpect(input string tag, input int value);
    expect_t e;
    e.tag   = tag;
    e.value = value;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input int observed);
    expect_t e;
    checkCount++;
    if (scoreboard.size() == 0) begin
      errorCount++;
      $error("[TB] FAIL scoreboard_empty: observed %0d, nothing expected", observed);
    end else begin
      e = scoreboard.pop_front();
      assert (observed === e.value) else begin
        errorCount++;
        $error("[TB] FAIL %s: observed %0d required %0d", e.tag, observed, e.value);
      end
    end
  endtask

  task automatic applyStimulus(input logic [NUM_LEDS*8-1:0] d, input logic [7:0] gp,
                               input logic [7:0] gf, input logic db,
                               input logic [NUM_LEDS*2-1:0] lo, input logic sl);
    duty    = d;
    grppwm  = gp;
    grpfreq = gf;
    dmblnk  = db;
    ledout  = lo;
    sleep   = sl;
  endtask

  // Leaves the bench on the negedge where period_wrap is high (pwm_cnt = 255).
  task automatic waitWrap();
    int found;
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      step();
      if (periodWrap) found = 1;
    end
    pushExpect("wait_wrap_bound", 1);
    checkOutput(found);
  endtask

  // Window of 256 negedges; entry i shows leds computed from pwm_cnt = i of the period.
  task automatic measure(input int led, input int changeAt, input logic [7:0] newDuty,
                         output int lit, output int wrapIdx);
    lit     = 0;
    wrapIdx = -1;
    for (int i = 0; i < 256; i++) begin
      step();
      if (leds[led]) lit++;
      if (periodWrap) wrapIdx = (wrapIdx == -1) ? i : -2;
      if (i == changeAt) duty[7:0] = newDuty;
    end
  endtask

  initial begin
    int lit;
    int wrapIdx;
    int steps;
    int litA;
    int litB;
    int at1022;
    int at1024;
    int at2048;
    int bad;

    reset = 1'b1;
    applyStimulus('0, 8'd0, 8'd0, 1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    pushExpect("reset_leds", 0);
    checkOutput(int'(leds));
    pushExpect("reset_period_wrap", 0);
    checkOutput(int'(periodWrap));

    // All LEDs fully on, but only once the first wrap loads the shadows.
    applyStimulus('0, 8'd0, 8'd0, 1'b0, 8'h55, 1'b0);
    reset     = 1'b0;
    wrapCount = 0;
    waitWrap();
    pushExpect("leds_at_first_wrap", 0);
    checkOutput(int'(leds));
    step();
    pushExpect("leds_1st_cycle_after_wrap", 0);
    checkOutput(int'(leds));
    step();
    pushExpect("leds_2nd_cycle_after_wrap", 15);
    checkOutput(int'(leds));

    waitWrap();
    steps = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      steps++;
      if (periodWrap) break;
    end
    pushExpect("wrap_spacing", 256);
    checkOutput(steps);

    // LED0 individual PWM at duty 64, driven on the wrap cycle so it loads at once.
    applyStimulus(32'd64, 8'd0, 8'd0, 1'b0, 8'h02, 1'b0);
    step();
    pushExpect("duty64_lit", 64);
    pushExpect("duty64_wrap_pos", 254);
    measure(0, -1, 8'd0, lit, wrapIdx);
    checkOutput(lit);
    checkOutput(wrapIdx);

    // Mid-period write at pwm_cnt = 100 must wait for the wrap.
    pushExpect("midwrite_old_period", 64);
    pushExpect("midwrite_wrap_pos", 254);
    measure(0, 99, 8'd200, lit, wrapIdx);
    checkOutput(lit);
    checkOutput(wrapIdx);
    pushExpect("midwrite_new_period", 200);
    pushExpect("midwrite_new_wrap_pos", 254);
    measure(0, -1, 8'd0, lit, wrapIdx);
    checkOutput(lit);
    checkOutput(wrapIdx);

    // Dimming: group phase equals wraps since reset; phases >= 128 are dark.
    applyStimulus(32'd255, 8'd128, 8'd0, 1'b0, 8'h03, 1'b0);
    for (int k = 0; k < 200 && wrapCount < 127; k++) waitWrap();
    pushExpect("dim_reached_phase", 127);
    checkOutput(wrapCount);
    step();
    pushExpect("dim_phase127_lit", 255);
    measure(0, -1, 8'd255, lit, wrapIdx);
    checkOutput(lit);
    pushExpect("dim_phase128_lit", 0);
    measure(0, -1, 8'd255, lit, wrapIdx);
    checkOutput(lit);
    pushExpect("dim_phase129_lit", 0);
    pushExpect("dim_phase129_wrap_pos", 254);
    measure(0, -1, 8'd255, lit, wrapIdx);
    checkOutput(lit);
    checkOutput(wrapIdx);

    // Blinking: phase every 8 clk, on for 1024 clk then off for 1024 clk.
    applyStimulus(32'd255, 8'd128, 8'd1, 1'b1, 8'h03, 1'b0);
    waitWrap();
    step();
    litA = 0;
    litB = 0;
    at1022 = -1;
    at1024 = -1;
    at2048 = -1;
    for (int t = 0; t <= 2048; t++) begin
      step();
      if (t < 1024) litA += int'(leds[0]);
      else if (t < 2048) litB += int'(leds[0]);
      if (t == 1022) at1022 = int'(leds[0]);
      if (t == 1024) at1024 = int'(leds[0]);
      if (t == 2048) at2048 = int'(leds[0]);
    end
    pushExpect("blink_on_half_lit", 1020);
    checkOutput(litA);
    pushExpect("blink_off_half_lit", 0);
    checkOutput(litB);
    pushExpect("blink_t1022", 1);
    checkOutput(at1022);
    pushExpect("blink_t1024", 0);
    checkOutput(at1024);
    pushExpect("blink_t2048", 1);
    checkOutput(at2048);

    // Sleep mid-period, new duty written while asleep.
    applyStimulus(32'd64, 8'd0, 8'd0, 1'b0, 8'h02, 1'b0);
    waitWrap();
    repeat (11) step();
    pushExpect("pre_sleep_lit", 1);
    checkOutput(int'(leds[0]));
    applyStimulus(32'd200, 8'd0, 8'd0, 1'b0, 8'h02, 1'b1);
    step();
    pushExpect("sleep_leds", 0);
    checkOutput(int'(leds));
    pushExpect("sleep_period_wrap", 0);
    checkOutput(int'(periodWrap));
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (leds != '0 || periodWrap) bad++;
    end
    pushExpect("sleep_hold_activity", 0);
    checkOutput(bad);

    sleep = 1'b0;
    pushExpect("wake_first_period_lit", 64);
    pushExpect("wake_first_wrap_pos", 254);
    measure(0, -1, 8'd200, lit, wrapIdx);
    checkOutput(lit);
    checkOutput(wrapIdx);
    pushExpect("wake_second_period_lit", 200);
    pushExpect("wake_second_wrap_pos", 254);
    measure(0, -1, 8'd200, lit, wrapIdx);
    checkOutput(lit);
    checkOutput(wrapIdx);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/led_pwm_engine.md
Name: led_pwm_engine

Overview:
Output stage directly downstream of the LED register file: consumes the per-LED duty, group PWM/frequency and LED output-select register values and produces the four LED pin levels. It runs on the internal 400 kHz oscillator clock, generates an 8-bit individual PWM per LED, and applies a shared group stage (dimming or blinking). Register updates take effect glitch-free at PWM period boundaries.

Parameters:
NUM_LEDS, 4, number of LED channels (duty bus is NUM_LEDS*8 bits, ledout is NUM_LEDS*2 bits)
BLINK_PRESCALE, 64, clk cycles per blink tick in blink mode; must be at least 2

Ports:
clk       input   1               internal oscillator clock (clk_osc, 400 kHz)
reset     input   1               asynchronous, active-high reset
sleep     input   1               MODE sleep bit; 1 = engine halted, LEDs off
duty      input   NUM_LEDS*8      individual PWM duty; LED i uses bits [8i+7:8i]
grppwm    input   8               group duty (dimming) or blink on-ratio
grpfreq   input   8               blink period select; period = (grpfreq+1) blink ticks per phase step
dmblnk    input   1               0 = group dimming, 1 = group blinking
ledout    input   NUM_LEDS*2      per LED: 00 off, 01 fully on, 10 individual PWM, 11 individual PWM AND group
leds      output  NUM_LEDS        LED drive, 1 = LED lit
period_wrap output 1              one-cycle pulse on the last cycle of each individual PWM period

Behaviour:
- Reset (async assert): leds = 0, period_wrap = 0, all counters and shadow registers = 0. Deassertion takes effect on the next clk edge.
- pwm_cnt: 8-bit free-running counter, +1 per clk, wraps 255->0. period_wrap = 1 during the cycle when pwm_cnt == 255.
- Shadow registers: duty, grppwm, grpfreq, dmblnk and ledout are sampled into shadows only on the clk edge where pwm_cnt == 255. New values govern outputs from pwm_cnt == 0 onward. A mid-period write has no effect until the wrap.
- Individual compare: ind_on[i] = (pwm_cnt < duty_sh[i]). Duty 0 is always off; duty 255 is on 255 of 256 cycles.
- Group phase counter grp_cnt (8-bit, wraps 255->0):
  - Dimming (dmblnk_sh = 0): +1 on each period_wrap.
  - Blinking (dmblnk_sh = 1): prescaler counts 0..BLINK_PRESCALE-1 and issues a tick on its terminal count. A divider counts ticks 0..grpfreq_sh and advances grp_cnt by 1 on its terminal count.
- grp_on = (grp_cnt < grppwm_sh).
- Mode change (dmblnk_sh differs from its previous value at a wrap): clear the prescaler, the divider and grp_cnt in that same cycle.
- Output select: 00 -> 0; 01 -> 1; 10 -> ind_on; 11 -> ind_on & grp_on.
- leds is registered. The value computed from pwm_cnt = N appears on leds in the cycle after pwm_cnt = N (1-cycle latency).
- Sleep: while sleep = 1, the following are held at 0 synchronously every cycle: pwm_cnt, grp_cnt, prescaler, divider, leds and period_wrap. Shadows are held. On sleep 1->0, counting restarts from pwm_cnt = 0, and shadows are reloaded at the first wrap.
- Reset taking priority over sleep and mid-period: all state returns to its reset value immediately.

Optional Feature:
LED_ACTIVE_LOW_EN. When defined, the leds output is inverted for open-drain active-low pins: the reset and sleep value of leds is all-ones, and a lit LED drives 0. period_wrap and all internal state are unaffected. When undefined, leds is active-high as described above.

Test Plan:
- Reset then release, ledout = 8'h55, sleep = 0 -> leds = 4'hF from the 2nd cycle after the first wrap. Before that, leds = 0 because the shadows are still 0.
- duty[7:0] = 64, ledout[1:0] = 10 -> leds[0] high for exactly 64 of every 256 cycles and low for the remaining 192. period_wrap pulses every 256 cycles.
- Duty changed 64 -> 200 at pwm_cnt = 100 -> the current period still shows 64 high cycles. The next period shows 200.
- Dimming: duty = 255, grppwm = 128, ledout = 11 -> LED is active during group phases 0..127 and fully dark for phases 128..255, i.e. 128 consecutive periods off.
- Blinking: dmblnk = 1, grpfreq = 1, BLINK_PRESCALE = 4, grppwm = 128 -> grp_cnt advances every 8 clk. grp_on is high for 1024 clk, then low for 1024 clk.
- sleep asserted mid-period -> leds = 0 on the next clk edge. On release, pwm_cnt restarts at 0 and the duty set during sleep becomes active from the second period.
